// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control slice.
// Contents: opcode constants, pc_sel / forwarding encodings, the hazard FSM
// state type, and the forwarding-select helper used by forward_unit.
package mips_pkg;

   localparam logic [5:0] OP_R   = 6'd0;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_SW  = 6'd43;
   localparam logic [5:0] OP_BEQ = 6'd4;
   localparam logic [5:0] OP_J   = 6'd2;

   localparam logic [1:0] PC_SEL_PC4    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_t;

   // The younger producer (EX/MEM) wins when both later stages match.
   // Register 0 never forwards since it is hard-wired to zero.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       mem_wr,
                                          input logic [4:0] mem_reg,
                                          input logic       wb_wr,
                                          input logic [4:0] wb_reg);
      if (mem_wr && (mem_reg != 5'd0) && (mem_reg == src))
         return FWD_EXMEM;
      else if (wb_wr && (wb_reg != 5'd0) && (wb_reg == src))
         return FWD_MEMWB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// ALU operand forwarding select for the EX stage (purely combinational).
// Ports:
//   ex_rs, ex_rt              source registers of the instruction in EX
//   mem_regwrite, mem_wreg    pending write in EX/MEM
//   wb_regwrite, wb_wreg      pending write in MEM/WB
//   fwd_a, fwd_b              operand source selects (FWD_* encoding)
module forward_unit
   import mips_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       mem_regwrite,
   input  logic [4:0] mem_wreg,
   input  logic       wb_regwrite,
   input  logic [4:0] wb_wreg,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   always_comb begin
      fwd_a = fwd_sel(ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
      fwd_b = fwd_sel(ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall / flush / forwarding sequencer for the 5-stage pipeline.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_*, ex_*, mem_*, wb_*   register indices and control bits per stage
//   dmem_req, dmem_ready      data-memory handshake from the MEM stage
//   pc_en, ifid_en, pipe_en   pipeline register enables
//   ifid_flush, idex_flush, exmem_flush   bubble insertion
//   pc_sel                    next-PC source (PC_SEL_* encoding)
//   fwd_a, fwd_b              ALU operand forwarding selects
//   stall_cnt, flush_cnt      saturating performance counters
//   err_timeout               sticky data-memory timeout flag
//
// state       | meaning
// ST_RUN      | normal issue; hazards resolved combinationally
// ST_MEM_WAIT | data memory busy, whole pipeline frozen
module pipe_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       ex_wreg,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_wreg,
   input  logic             mem_branch_taken,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_wreg,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             pipe_en,
   output logic [1:0]       pc_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             err_timeout
);

   localparam int            WW      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WC_LAST = WW'(MEM_TIMEOUT - 1);

   hz_state_t     state, state_nx;
   logic [WW-1:0] wait_cnt;
   logic          timeout_hit;
   logic          mem_stall;
   logic          load_use;
   logic          flush_evt;
   logic          timeout_fire;
   logic [1:0]    fwd_a_raw, fwd_b_raw;

   forward_unit u_fwd (
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .mem_regwrite (mem_regwrite),
      .mem_wreg     (mem_wreg),
      .wb_regwrite  (wb_regwrite),
      .wb_wreg      (wb_wreg),
      .fwd_a        (fwd_a_raw),
      .fwd_b        (fwd_b_raw)
   );

   // ex_regwrite is implied by ex_memread for loads; the hazard keys off memread.
   assign load_use = ex_memread && (ex_wreg != 5'd0) &&
                     ((ex_wreg == id_rs) || (id_uses_rt && (ex_wreg == id_rt)));

   // On the last allowed wait cycle the access is abandoned and the pipe released.
   assign timeout_hit  = (state == ST_MEM_WAIT) && (wait_cnt == WC_LAST);
   assign timeout_fire = timeout_hit && dmem_req && !dmem_ready;
   assign mem_stall    = dmem_req && !dmem_ready && !timeout_hit;

   always_comb begin
      state_nx    = state;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_sel      = PC_SEL_PC4;
      flush_evt   = 1'b0;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;

      if (rst) begin
         state_nx    = ST_RUN;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         pipe_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         fwd_a       = FWD_RF;
         fwd_b       = FWD_RF;
      end else if (mem_stall) begin
         state_nx = ST_MEM_WAIT;
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         pipe_en  = 1'b0;
      end else begin
         state_nx = ST_RUN;
         if (mem_branch_taken) begin
            pc_sel      = PC_SEL_BRANCH;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
         end else if (load_use) begin
            // A jump in ID stays put and is taken once the bubble has passed.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (id_jump) begin
            pc_sel     = PC_SEL_JUMP;
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         err_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == ST_MEM_WAIT) && (state_nx == ST_MEM_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (!pc_en && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_evt && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
         if (timeout_fire)
            err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
   import mips_pkg::*;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
   logic             id_uses_rt, id_jump, ex_memread, ex_regwrite;
   logic             mem_regwrite, mem_branch_taken, wb_regwrite;
   logic             dmem_req, dmem_ready;
   logic             pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_en;
   logic [1:0]       pc_sel, fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             err_timeout;

   // {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, pc_sel}
   wire [7:0] ctl = {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, pc_sel};

   localparam logic [7:0] CTL_RST    = 8'b000_111_00;
   localparam logic [7:0] CTL_RUN    = 8'b111_000_00;
   localparam logic [7:0] CTL_LU     = 8'b001_010_00;
   localparam logic [7:0] CTL_BR     = 8'b111_111_01;
   localparam logic [7:0] CTL_JMP    = 8'b111_100_10;
   localparam logic [7:0] CTL_MSTALL = 8'b000_000_00;

   int n_vec = 0;
   int n_err = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
      .mem_branch_taken(mem_branch_taken), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .pipe_en(pipe_en), .pc_sel(pc_sel),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
      ex_rs = 0; ex_rt = 0; ex_memread = 0; ex_regwrite = 0; ex_wreg = 0;
      mem_regwrite = 0; mem_wreg = 0; mem_branch_taken = 0;
      wb_regwrite = 0; wb_wreg = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   // Advance one clock; inputs are changed 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu();
      ex_memread = 1; ex_regwrite = 1; ex_wreg = 5'd2; id_rs = 5'd2;
   endtask

   initial begin
      idle();
      rst = 1;
      mem_regwrite = 1; mem_wreg = 5'd3; ex_rs = 5'd3;
      #1;
      chk("rst_ctl", 32'(ctl), 32'(CTL_RST));
      chk("rst_fwd_a", 32'(fwd_a), 32'(FWD_RF));
      tick(); tick();
      rst = 0; idle(); #1;
      chk("idle_ctl", 32'(ctl), 32'(CTL_RUN));
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_state", 32'(dut.state), 32'(ST_RUN));

      // load-use on rs: exactly one bubble
      set_lu(); #1;
      chk("lu_rs_ctl", 32'(ctl), 32'(CTL_LU));
      tick(); idle(); #1;
      chk("lu_after_ctl", 32'(ctl), 32'(CTL_RUN));
      chk("lu_stall_cnt", 32'(stall_cnt), 1);

      // rt dependence only counts when ID reads rt
      ex_memread = 1; ex_wreg = 5'd5; id_rt = 5'd5; id_uses_rt = 0; #1;
      chk("lu_rt_unused", 32'(ctl), 32'(CTL_RUN));
      id_uses_rt = 1; #1;
      chk("lu_rt_used", 32'(ctl), 32'(CTL_LU));
      tick(); idle();
      ex_memread = 1; ex_wreg = 5'd0; id_rs = 5'd0; #1;
      chk("lu_r0", 32'(ctl), 32'(CTL_RUN));
      chk("lu_rt_stall_cnt", 32'(stall_cnt), 2);
      idle();

      // forwarding priority
      mem_regwrite = 1; mem_wreg = 5'd3; wb_regwrite = 1; wb_wreg = 5'd3; ex_rs = 5'd3; #1;
      chk("fwd_a_mem", 32'(fwd_a), 32'(FWD_EXMEM));
      chk("fwd_b_none", 32'(fwd_b), 32'(FWD_RF));
      mem_regwrite = 0; #1;
      chk("fwd_a_wb", 32'(fwd_a), 32'(FWD_MEMWB));
      mem_regwrite = 1; mem_wreg = 5'd0; wb_wreg = 5'd0; ex_rs = 5'd0; #1;
      chk("fwd_a_r0", 32'(fwd_a), 32'(FWD_RF));
      idle();
      mem_regwrite = 1; mem_wreg = 5'd7; ex_rt = 5'd7; wb_regwrite = 1; wb_wreg = 5'd9; ex_rs = 5'd9; #1;
      chk("fwd_b_mem", 32'(fwd_b), 32'(FWD_EXMEM));
      chk("fwd_a_wb2", 32'(fwd_a), 32'(FWD_MEMWB));
      idle();

      // branch beats load-use
      mem_branch_taken = 1; set_lu(); #1;
      chk("br_lu_ctl", 32'(ctl), 32'(CTL_BR));
      tick(); idle(); #1;
      chk("br_flush_cnt", 32'(flush_cnt), 1);
      chk("br_stall_cnt", 32'(stall_cnt), 2);

      // plain jump
      id_jump = 1; #1;
      chk("jmp_ctl", 32'(ctl), 32'(CTL_JMP));
      tick(); #1;
      chk("jmp_flush_cnt", 32'(flush_cnt), 2);

      // jump deferred behind load-use
      set_lu(); #1;
      chk("jmp_lu_ctl", 32'(ctl), 32'(CTL_LU));
      tick(); ex_memread = 0; #1;
      chk("jmp_retry_ctl", 32'(ctl), 32'(CTL_JMP));
      tick(); idle(); #1;
      chk("jmp_retry_flush", 32'(flush_cnt), 3);
      chk("jmp_retry_stall", 32'(stall_cnt), 3);

      // memory stall for 3 cycles, branch held off until released
      dmem_req = 1; dmem_ready = 0; mem_branch_taken = 1;
      mem_regwrite = 1; mem_wreg = 5'd4; ex_rt = 5'd4; #1;
      chk("ms_c1_ctl", 32'(ctl), 32'(CTL_MSTALL));
      chk("ms_fwd_b", 32'(fwd_b), 32'(FWD_EXMEM));
      tick();
      chk("ms_c2_ctl", 32'(ctl), 32'(CTL_MSTALL));
      chk("ms_state", 32'(dut.state), 32'(ST_MEM_WAIT));
      tick();
      chk("ms_c3_ctl", 32'(ctl), 32'(CTL_MSTALL));
      tick(); dmem_ready = 1; #1;
      chk("ms_ready_ctl", 32'(ctl), 32'(CTL_BR));
      tick(); idle(); #1;
      chk("ms_exit_state", 32'(dut.state), 32'(ST_RUN));
      chk("ms_stall_cnt", 32'(stall_cnt), 6);
      chk("ms_flush_cnt", 32'(flush_cnt), 4);

      // timeout: 1 stall in RUN, then 4 MEM_WAIT cycles, the 4th releases
      dmem_req = 1; dmem_ready = 0; #1;
      chk("to_c0_ctl", 32'(ctl), 32'(CTL_MSTALL));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_wait_ctl", 32'(ctl), 32'(CTL_MSTALL));
      end
      tick();
      chk("to_release_ctl", 32'(ctl), 32'(CTL_RUN));
      chk("to_err_pre", 32'(err_timeout), 0);
      tick(); dmem_req = 0; #1;
      chk("to_err", 32'(err_timeout), 1);
      chk("to_state", 32'(dut.state), 32'(ST_RUN));
      chk("to_stall_cnt", 32'(stall_cnt), 10);
      tick(); tick();
      chk("to_err_sticky", 32'(err_timeout), 1);

      // saturation of both counters (4 bits)
      set_lu();
      for (int i = 0; i < 8; i++) tick();
      chk("sat_stall_cnt", 32'(stall_cnt), 15);
      idle(); id_jump = 1;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_flush_cnt", 32'(flush_cnt), 15);
      idle();

      // reset in the middle of a memory wait
      dmem_req = 1; dmem_ready = 0;
      tick(); tick();
      chk("rw_state", 32'(dut.state), 32'(ST_MEM_WAIT));
      rst = 1; #1;
      chk("rw_rst_ctl", 32'(ctl), 32'(CTL_RST));
      tick(); rst = 0; idle(); #1;
      chk("rw_state_run", 32'(dut.state), 32'(ST_RUN));
      chk("rw_stall_cnt", 32'(stall_cnt), 0);
      chk("rw_flush_cnt", 32'(flush_cnt), 0);
      chk("rw_err", 32'(err_timeout), 0);
      chk("rw_ctl", 32'(ctl), 32'(CTL_RUN));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
